// File: rtl/mmu_pkg.sv
// rtl/mmu_pkg.sv - shared MMU types and constants for the PTW request scheduler
package mmu_pkg;

  localparam int PTW_SCHED_MAX_REQ = 8;
  localparam int IDX_ITLB          = 0;
  localparam int IDX_DTLB          = 1;

  // TLB miss request towards the page-table walker
  typedef struct packed {
    logic [26:0] vpn;
    logic [1:0]  prv;
    logic        store;
    logic        fetch;
  } tlb_ptw_req_t;

  // Walker result; valid doubles as the response strobe
  typedef struct packed {
    logic        valid;
    logic        error;
    logic [1:0]  level;
    logic [63:0] pte;
  } ptw_tlb_resp_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_DRAIN
  } ptw_sched_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin first-one finder
module rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0]         vld,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] idx,
  output logic                 found
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] cand;

  // Scan downward so the last hit written is the closest index at or above ptr
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = IW'((int'(ptr) + i) % N);
      if (vld[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ptw_req_sched.sv
// rtl/ptw_req_sched.sv - round-robin PTW scheduler for NUM_REQ TLBs (optional PTW_SCHED_DEDUP_EN)
module ptw_req_sched
  import mmu_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NUM_REQ-1:0]  req_valid_i,
  input  tlb_ptw_req_t        req_i [NUM_REQ],
  output logic [NUM_REQ-1:0]  req_ready_o,
  output logic [NUM_REQ-1:0]  resp_valid_o,
  output ptw_tlb_resp_t       resp_o,
  output logic                ptw_req_valid_o,
  output tlb_ptw_req_t        ptw_req_o,
  input  logic                ptw_ready_i,
  input  ptw_tlb_resp_t       ptw_resp_i,
  input  logic                flush_i,
  output logic                busy_o
);

  localparam int                 IW  = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  ptw_sched_state_t   state_q, state_d;
  logic [NUM_REQ-1:0] slot_vld_q;
  tlb_ptw_req_t       slot_q [NUM_REQ];
  logic [NUM_REQ-1:0] accept;
  logic [NUM_REQ-1:0] gnt_mask;
  logic [NUM_REQ-1:0] resp_mask;
  logic [IW-1:0]      rr_ptr_q;
  logic [IW-1:0]      gnt_idx_q;
  logic [IW-1:0]      pick_idx;
  logic               pick_found;
  logic               grant;
  ptw_tlb_resp_t      resp_q;

  // Ready only reflects slot occupancy and flush; reset holds it low too
  assign req_ready_o = ~slot_vld_q & {NUM_REQ{~flush_i & ~rst_i}};
  assign accept      = req_valid_i & req_ready_o;
  assign gnt_mask    = ONE << gnt_idx_q;
  assign busy_o      = (|slot_vld_q) | (state_q != S_IDLE);

  rr_pick #(
    .N (NUM_REQ)
  ) u_rr_pick (
    .vld   (slot_vld_q),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

`ifdef PTW_SCHED_DEDUP_EN
  logic [NUM_REQ-1:0] rider_q, rider_d;

  // Other pending slots translating the same page at the same privilege share this walk
  always_comb begin
    rider_d = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (slot_vld_q[k] && (IW'(k) != pick_idx) &&
          (slot_q[k].vpn == slot_q[pick_idx].vpn) &&
          (slot_q[k].prv == slot_q[pick_idx].prv)) begin
        rider_d[k] = 1'b1;
      end
    end
  end

  // Rider set is captured with the grant and dropped on flush
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rider_q <= '0;
    end else if (grant) begin
      rider_q <= rider_d;
    end else if (flush_i) begin
      rider_q <= '0;
    end
  end

  assign resp_mask = (state_q == S_RESP) ? (gnt_mask | rider_q) : '0;
`else
  assign resp_mask = (state_q == S_RESP) ? gnt_mask : '0;
`endif

  // Delivery strobe and payload exist only in S_RESP so outputs idle at zero
  assign resp_valid_o = resp_mask;
  assign resp_o       = (state_q == S_RESP) ? resp_q : '0;

  // Slot bookkeeping: capture on accept, free on delivery, wipe on flush
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_vld_q <= '0;
      for (int k = 0; k < NUM_REQ; k++) slot_q[k] <= '0;
    end else begin
      if (flush_i) slot_vld_q <= '0;
      else         slot_vld_q <= (slot_vld_q & ~resp_mask) | accept;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (accept[k]) slot_q[k] <= req_i[k];
      end
    end
  end

  // Grant latch and round-robin pointer advance past the winner
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gnt_idx_q <= '0;
      rr_ptr_q  <= '0;
    end else if (grant) begin
      gnt_idx_q <= pick_idx;
      if (pick_idx == IW'(NUM_REQ - 1)) rr_ptr_q <= '0;
      else                              rr_ptr_q <= pick_idx + IW'(1);
    end
  end

  // Hold the walker result for the single delivery cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      resp_q <= '0;
    end else if ((state_q == S_WAIT) && ptw_resp_i.valid && !flush_i) begin
      resp_q <= ptw_resp_i;
    end
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state and walker-side outputs
  always_comb begin
    state_d         = state_q;
    grant           = 1'b0;
    ptw_req_valid_o = 1'b0;
    ptw_req_o       = '0;
    case (state_q)
      S_IDLE: begin
        // No grant under flush: the slot being picked is about to vanish
        if (!flush_i && pick_found) begin
          grant   = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        ptw_req_valid_o = 1'b1;
        ptw_req_o       = slot_q[gnt_idx_q];
        // A walk accepted in the flush cycle still owes us a response to drop
        if (flush_i)          state_d = ptw_ready_i ? S_DRAIN : S_IDLE;
        else if (ptw_ready_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (ptw_resp_i.valid) state_d = flush_i ? S_IDLE : S_RESP;
        else if (flush_i)     state_d = S_DRAIN;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (ptw_resp_i.valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ptw_req_sched.sv
// tb/tb_ptw_req_sched.sv - self-checking bench for ptw_req_sched
module tb_ptw_req_sched;
  import mmu_pkg::*;

  localparam int N = 2;
`ifdef PTW_SCHED_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid, req_ready, resp_valid;
  tlb_ptw_req_t  req [N];
  ptw_tlb_resp_t resp, ptw_resp;
  logic          ptw_req_valid, ptw_ready, flush, busy;
  tlb_ptw_req_t  ptw_req;
  int            ncmp = 0;
  int            nfail = 0;
  int            rr_model = 0;

  always #5 clk = ~clk;

  ptw_req_sched #(.NUM_REQ(N)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req_valid_i     (req_valid),
    .req_i           (req),
    .req_ready_o     (req_ready),
    .resp_valid_o    (resp_valid),
    .resp_o          (resp),
    .ptw_req_valid_o (ptw_req_valid),
    .ptw_req_o       (ptw_req),
    .ptw_ready_i     (ptw_ready),
    .ptw_resp_i      (ptw_resp),
    .flush_i         (flush),
    .busy_o          (busy)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = '0;
    ptw_ready = 1'b0;
    ptw_resp  = '0;
    flush     = 1'b0;
    for (int k = 0; k < N; k++) req[k] = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    settle();
    chk("rst_ptw_req_valid", ptw_req_valid, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    settle();
    chk("rst_req_ready", req_ready, {N{1'b1}});
    rr_model = 0;
  endtask

  task automatic wait_issue(input string tag, output int waited);
    waited = 0;
    settle();
    while (ptw_req_valid !== 1'b1 && waited < 20) begin
      tick();
      settle();
      waited++;
    end
    chk({tag, "_issue"}, ptw_req_valid, 1);
  endtask

  // One batch of simultaneous misses, walked to completion with a random PTW
  task automatic run_round(input logic [N-1:0] mask, input bit fixed_err);
    tlb_ptw_req_t  pay [N];
    logic [N-1:0]  pend, rmask;
    ptw_tlb_resp_t r;
    int            g, waited, d;
    for (int k = 0; k < N; k++) begin
      pay[k] = '{vpn: 27'($urandom_range(0, 3)), prv: 2'($urandom_range(0, 1)),
                 store: 1'($urandom_range(0, 1)), fetch: (k == IDX_ITLB)};
      req[k] = pay[k];
    end
    req_valid = mask;
    settle();
    chk("round_ready", req_ready, {N{1'b1}});
    tick();
    req_valid = '0;
    pend = mask;
    while (pend != '0) begin
      g = -1;
      for (int i = 0; i < N; i++) begin
        int c;
        c = (rr_model + i) % N;
        if (pend[c] && g < 0) g = c;
      end
      rmask = '0;
      rmask[g] = 1'b1;
      for (int k = 0; k < N; k++) begin
        if (DEDUP && k != g && pend[k] && pay[k].vpn == pay[g].vpn && pay[k].prv == pay[g].prv)
          rmask[k] = 1'b1;
      end
      wait_issue("round", waited);
      chk("round_issue_latency", waited, 1);
      chk("round_req_payload", ptw_req, pay[g]);
      d = $urandom_range(0, 2);
      repeat (d) begin
        tick();
        settle();
        chk("round_hold_valid", ptw_req_valid, 1);
        chk("round_hold_payload", ptw_req, pay[g]);
      end
      ptw_ready = 1'b1;
      tick();
      ptw_ready = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
      settle();
      chk("round_no_early_resp", resp_valid, 0);
      r.valid = 1'b1;
      r.error = fixed_err ? 1'b1 : 1'($urandom_range(0, 1));
      r.level = fixed_err ? 2'd2 : 2'($urandom_range(0, 2));
      r.pte   = {$urandom, $urandom};
      ptw_resp = r;
      tick();
      ptw_resp = '0;
      settle();
      chk("round_resp_valid", resp_valid, rmask);
      chk("round_resp_payload", resp, r);
      pend = pend & ~rmask;
      rr_model = (g + 1) % N;
      tick();
    end
    settle();
    chk("round_end_busy", busy, 0);
    chk("round_end_ready", req_ready, {N{1'b1}});
  endtask

  initial begin
    ptw_tlb_resp_t r1;
    int            w;
    do_reset();

    // Single iTLB miss, PTW ready at once, response in cycle 5
    req[IDX_ITLB] = '{vpn: 27'h12345, prv: 2'd0, store: 1'b0, fetch: 1'b1};
    req_valid = 2'b01;
    settle();
    chk("t1_ready_c0", req_ready, 2'b11);
    tick();                                   // cycle 1
    req_valid = '0;
    settle();
    chk("t1_no_issue_c1", ptw_req_valid, 0);
    chk("t1_slot_busy_c1", req_ready, 2'b10);
    tick();                                   // cycle 2
    settle();
    chk("t1_issue_c2", ptw_req_valid, 1);
    chk("t1_vpn_c2", ptw_req.vpn, 27'h12345);
    ptw_ready = 1'b1;
    tick();                                   // cycle 3
    ptw_ready = 1'b0;
    settle();
    chk("t1_dropped_valid_c3", ptw_req_valid, 0);
    tick();                                   // cycle 4
    tick();                                   // cycle 5
    r1 = '{valid: 1'b1, error: 1'b0, level: 2'd0, pte: 64'h0000_0000_2000_1c01};
    ptw_resp = r1;
    settle();
    chk("t1_no_resp_c5", resp_valid, 0);
    tick();                                   // cycle 6
    ptw_resp = '0;
    settle();
    chk("t1_resp_valid_c6", resp_valid, 2'b01);
    chk("t1_resp_c6", resp, r1);
    tick();                                   // cycle 7
    settle();
    chk("t1_resp_gone_c7", resp_valid, 0);
    chk("t1_ready_c7", req_ready, 2'b11);
    chk("t1_idle_c7", busy, 0);

    // Simultaneous pairs from a fresh pointer: 0 then 1, twice
    do_reset();
    run_round(2'b11, 1'b0);
    run_round(2'b11, 1'b0);

    // Flush while waiting; late PTW response must be swallowed
    do_reset();
    req[IDX_ITLB] = '{vpn: 27'h55, prv: 2'd1, store: 1'b0, fetch: 1'b1};
    req_valid = 2'b01;
    tick();                                   // cycle 1
    req_valid = '0;
    wait_issue("t3", w);
    ptw_ready = 1'b1;
    tick();                                   // WAIT
    ptw_ready = 1'b0;
    req[IDX_DTLB] = '{vpn: 27'h66, prv: 2'd1, store: 1'b1, fetch: 1'b0};
    req_valid = 2'b10;
    tick();                                   // flush cycle
    req_valid = '0;
    flush = 1'b1;
    settle();
    chk("t3_flush_ready", req_ready, 2'b00);
    tick();
    flush = 1'b0;
    settle();
    chk("t3_slots_empty", req_ready, 2'b11);
    chk("t3_drain_busy", busy, 1);
    tick();
    settle();
    chk("t3_no_resp_a", resp_valid, 0);
    tick();
    ptw_resp = '{valid: 1'b1, error: 1'b0, level: 2'd1, pte: 64'hdead};
    settle();
    chk("t3_no_resp_b", resp_valid, 0);
    tick();
    ptw_resp = '0;
    settle();
    chk("t3_no_resp_c", resp_valid, 0);
    chk("t3_idle", busy, 0);
    tick();
    settle();
    chk("t3_no_rewalk", ptw_req_valid, 0);

    // Flush together with a dTLB request and a PTW handshake in S_ISSUE
    do_reset();
    req[IDX_ITLB] = '{vpn: 27'h77, prv: 2'd0, store: 1'b0, fetch: 1'b1};
    req_valid = 2'b01;
    tick();
    req_valid = '0;
    wait_issue("t4", w);
    req[IDX_DTLB] = '{vpn: 27'h88, prv: 2'd0, store: 1'b0, fetch: 1'b0};
    req_valid = 2'b10;
    ptw_ready = 1'b1;
    flush     = 1'b1;
    settle();
    chk("t4_flush_ready", req_ready, 2'b00);
    tick();
    req_valid = '0;
    ptw_ready = 1'b0;
    flush     = 1'b0;
    settle();
    chk("t4_no_issue", ptw_req_valid, 0);
    chk("t4_drain_busy", busy, 1);
    tick();
    ptw_resp = '{valid: 1'b1, error: 1'b0, level: 2'd0, pte: 64'hbeef};
    tick();
    ptw_resp = '0;
    settle();
    chk("t4_no_resp", resp_valid, 0);
    chk("t4_idle", busy, 0);
    tick();
    settle();
    chk("t4_dtlb_dropped", ptw_req_valid, 0);

    // Error response for the dTLB is routed like any other
    do_reset();
    run_round(2'b10, 1'b1);

`ifdef PTW_SCHED_DEDUP_EN
    // Identical misses from both TLBs share one walk
    do_reset();
    for (int k = 0; k < N; k++)
      req[k] = '{vpn: 27'habc, prv: 2'd1, store: 1'b0, fetch: (k == IDX_ITLB)};
    req_valid = 2'b11;
    tick();
    req_valid = '0;
    wait_issue("dd", w);
    ptw_ready = 1'b1;
    tick();
    ptw_ready = 1'b0;
    r1 = '{valid: 1'b1, error: 1'b0, level: 2'd0, pte: 64'h1234};
    ptw_resp = r1;
    tick();
    ptw_resp = '0;
    settle();
    chk("dd_resp_valid", resp_valid, 2'b11);
    chk("dd_resp", resp, r1);
    tick();
    tick();
    settle();
    chk("dd_single_walk", ptw_req_valid, 0);
    chk("dd_idle", busy, 0);
`endif

    // Randomised batches against the round-robin model
    do_reset();
    repeat (40) run_round(N'($urandom_range(1, (1 << N) - 1)), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500000");
    $fatal(1);
  end

endmodule
